// File: rtl/if_pkg.sv
// Shared constants and types for the instruction-fetch stage.
package if_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [XLEN-1:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam logic [XLEN-1:0] PC_STEP          = 32'h0000_0004;
    localparam logic [XLEN-1:0] ALIGN_MASK       = 32'hFFFF_FFFC;

    typedef enum logic {
        S_FETCH = 1'b0,
        S_REDIR = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/if_hold_buf.sv
// One-entry holding register with valid flag; load takes priority over clear.
module if_hold_buf #(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic         clear_i,
    input  logic [W-1:0] data_i,
    output logic         valid_o,
    output logic [W-1:0] data_o
);

    logic         valid_q, valid_d;
    logic [W-1:0] data_q, data_d;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (load_i) begin
            valid_d = 1'b1;
            data_d  = data_i;
        end else if (clear_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage with IF/ID register, stall/redirect handling.
// Optional IF_PERF_CNT_EN adds bubble and flush performance counters.
module if_stage
    import if_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            IFWrite,
    input  logic            Branch,
    input  logic            Jump,
    input  logic [XLEN-1:0] JumpAddr,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ready,
    input  logic [XLEN-1:0] imem_rdata,
`ifdef IF_PERF_CNT_EN
    output logic [31:0]     perf_bubble_cnt,
    output logic [31:0]     perf_flush_cnt,
`endif
    output logic [XLEN-1:0] PC_id,
    output logic [XLEN-1:0] Instruction_id
);

    fetch_state_t    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] pc_id_q, pc_id_d;
    logic [XLEN-1:0] instr_id_q, instr_id_d;

    logic            hold_valid, hold_load, hold_clr;
    logic [XLEN-1:0] hold_instr;
    logic            redir_valid, redir_load, redir_clr;
    logic [XLEN-1:0] redir_pc;

    logic            redirect, handshake, redir_pending;
    logic            bubble, flush;
    logic [XLEN-1:0] target;

    assign redirect      = Branch | Jump;
    assign target        = JumpAddr & ALIGN_MASK;
    assign imem_req      = rst_n & ~hold_valid;
    assign imem_addr     = pc_q;
    assign handshake     = imem_req & imem_ready;
    assign redir_pending = (state_q == S_REDIR) & redir_valid;

    if_hold_buf #(.W(XLEN)) u_hold (
        .clk     (clk),
        .rst_n   (rst_n),
        .load_i  (hold_load),
        .clear_i (hold_clr),
        .data_i  (imem_rdata),
        .valid_o (hold_valid),
        .data_o  (hold_instr)
    );

    // Target parked while a wrong-path response is still in flight.
    if_hold_buf #(.W(XLEN)) u_redir (
        .clk     (clk),
        .rst_n   (rst_n),
        .load_i  (redir_load),
        .clear_i (redir_clr),
        .data_i  (target),
        .valid_o (redir_valid),
        .data_o  (redir_pc)
    );

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        pc_id_d    = pc_id_q;
        instr_id_d = instr_id_q;
        hold_load  = 1'b0;
        hold_clr   = 1'b0;
        redir_load = 1'b0;
        redir_clr  = 1'b0;
        bubble     = 1'b0;
        flush      = 1'b0;

        if (!IFWrite) begin
            // Stall: decode re-evaluates redirects next cycle; only absorb the response.
            if (handshake && redir_pending) begin
                pc_d      = redir_pc;
                state_d   = S_FETCH;
                redir_clr = 1'b1;
            end else if (handshake && !hold_valid) begin
                hold_load = 1'b1;
            end
        end else if (redirect) begin
            pc_id_d    = pc_q;
            instr_id_d = NOP_INSTR;
            hold_clr   = 1'b1;
            flush      = 1'b1;
            if (hold_valid || handshake || !imem_req) begin
                pc_d      = target;
                state_d   = S_FETCH;
                redir_clr = 1'b1;
            end else begin
                redir_load = 1'b1;
                state_d    = S_REDIR;
            end
        end else if (redir_pending) begin
            pc_id_d    = pc_q;
            instr_id_d = NOP_INSTR;
            bubble     = 1'b1;
            if (handshake) begin
                pc_d      = redir_pc;
                state_d   = S_FETCH;
                redir_clr = 1'b1;
            end
        end else if (hold_valid) begin
            pc_id_d    = pc_q;
            instr_id_d = hold_instr;
            pc_d       = pc_q + PC_STEP;
            hold_clr   = 1'b1;
        end else if (handshake) begin
            pc_id_d    = pc_q;
            instr_id_d = imem_rdata;
            pc_d       = pc_q + PC_STEP;
        end else begin
            pc_id_d    = pc_q;
            instr_id_d = NOP_INSTR;
            bubble     = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_FETCH;
            pc_q       <= RESET_PC;
            pc_id_q    <= RESET_PC;
            instr_id_q <= NOP_INSTR;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            pc_id_q    <= pc_id_d;
            instr_id_q <= instr_id_d;
        end
    end

    assign PC_id          = pc_id_q;
    assign Instruction_id = instr_id_q;

`ifdef IF_PERF_CNT_EN
    logic [31:0] bubble_cnt_q, flush_cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bubble_cnt_q <= '0;
            flush_cnt_q  <= '0;
        end else begin
            if (bubble) bubble_cnt_q <= bubble_cnt_q + 32'd1;
            if (flush)  flush_cnt_q  <= flush_cnt_q + 32'd1;
        end
    end

    assign perf_bubble_cnt = bubble_cnt_q;
    assign perf_flush_cnt  = flush_cnt_q;
`else
    logic unused_cnt;
    assign unused_cnt = bubble ^ flush;
`endif

endmodule
